// File: rtl/risc_decode.sv
// Decode / operand-fetch stage: register file, write-back bypass,
// load-use stall and the registered bundle handed to execute.
module risc_decode #(
  parameter int DW   = 8,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [12:0]   ir,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [2:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          stall,
  output logic          ex_valid,
  output logic [3:0]    ex_op,
  output logic [2:0]    ex_rd,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic          ex_we,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic          ex_branch,
  output logic          illegal
);

  logic [3:0] op;
  logic [2:0] f1, f2, f3;

  assign op = ir[12:9];
  assign f1 = ir[8:6];
  assign f2 = ir[5:3];
  assign f3 = ir[2:0];

  logic [DW-1:0] rf [NREG];

  logic is_nop, is_alu, is_addi, is_ld;
  logic is_st, is_beq, is_jmp, is_ill;

  assign is_nop  = (op == 4'd0);
  assign is_alu  = (op >= 4'd1) && (op <= 4'd5);
  assign is_addi = (op == 4'd6);
  assign is_ld   = (op == 4'd7);
  assign is_st   = (op == 4'd8);
  assign is_beq  = (op == 4'd9);
  assign is_jmp  = (op == 4'd10);
  assign is_ill  = (op >= 4'd11);

  logic [2:0]    ra_idx, rb_idx;
  logic          use_a, use_b;
  logic [DW-1:0] ra_val, rb_val;
  logic [DW-1:0] sext3, zext5;

  logic          d_valid, d_we, d_ld, d_st, d_br, d_ill;
  logic [2:0]    d_rd;
  logic [DW-1:0] d_imm;

  assign sext3 = {{(DW-3){f3[2]}}, f3};
  assign zext5 = {{(DW-5){1'b0}}, ir[4:0]};

  // Source ports read the file, with r0 pinned to zero and the
  // same-cycle write-back forwarded ahead of the stored value.
  assign ra_val = (ra_idx == 3'd0) ? '0 :
                  (wb_en && wb_addr == ra_idx) ? wb_data :
                  rf[ra_idx];
  assign rb_val = (rb_idx == 3'd0) ? '0 :
                  (wb_en && wb_addr == rb_idx) ? wb_data :
                  rf[rb_idx];

  // Field decode: which sources are read and what the bundle carries.
  always_comb begin
    ra_idx  = 3'd0;
    rb_idx  = 3'd0;
    use_a   = 1'b0;
    use_b   = 1'b0;
    d_valid = 1'b0;
    d_we    = 1'b0;
    d_ld    = 1'b0;
    d_st    = 1'b0;
    d_br    = 1'b0;
    d_ill   = 1'b0;
    d_rd    = 3'd0;
    d_imm   = '0;
    unique case (1'b1)
      is_nop: ;
      is_alu: begin
        d_valid = 1'b1;
        d_we    = 1'b1;
        d_rd    = f1;
        ra_idx  = f2;
        rb_idx  = f3;
        use_a   = 1'b1;
        use_b   = 1'b1;
      end
      is_addi, is_ld: begin
        d_valid = 1'b1;
        d_we    = 1'b1;
        d_ld    = is_ld;
        d_rd    = f1;
        ra_idx  = f2;
        use_a   = 1'b1;
        d_imm   = sext3;
      end
      is_st: begin
        d_valid = 1'b1;
        d_st    = 1'b1;
        ra_idx  = f2;
        rb_idx  = f1;
        use_a   = 1'b1;
        use_b   = 1'b1;
        d_imm   = sext3;
      end
      is_beq: begin
        d_valid = 1'b1;
        d_br    = 1'b1;
        ra_idx  = f1;
        rb_idx  = f2;
        use_a   = 1'b1;
        use_b   = 1'b1;
        d_imm   = sext3;
      end
      is_jmp: begin
        d_valid = 1'b1;
        d_br    = 1'b1;
        d_imm   = zext5;
      end
      is_ill: d_ill = 1'b1;
      default: ;
    endcase
  end

  // Load-use: the load in execute produces a register this ir reads.
  always_comb begin
    stall = 1'b0;
    if (ex_valid && ex_mem_rd && ex_rd != 3'd0 && !flush)
      stall = (use_a && ra_idx == ex_rd) ||
              (use_b && rb_idx == ex_rd);
  end

  // Register file: r0 is never written; writes ignore stall/flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (wb_en && wb_addr != 3'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Execute bundle: bubble on flush or stall, else the decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_op     <= 4'd0;
      ex_rd     <= 3'd0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_imm    <= '0;
      ex_we     <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
      ex_branch <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush || stall) begin
      ex_valid  <= 1'b0;
      ex_op     <= 4'd0;
      ex_rd     <= 3'd0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_imm    <= '0;
      ex_we     <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
      ex_branch <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      ex_valid  <= d_valid;
      ex_op     <= d_valid ? op : 4'd0;
      ex_rd     <= d_rd;
      ex_a      <= use_a ? ra_val : '0;
      ex_b      <= use_b ? rb_val : '0;
      ex_imm    <= d_imm;
      ex_we     <= d_we;
      ex_mem_rd <= d_ld;
      ex_mem_wr <= d_st;
      ex_branch <= d_br;
      illegal   <= d_ill;
    end
  end

endmodule

// File: tb/tb_risc_decode.sv
// Directed bench for risc_decode: decode, bypass,
// load-use stall, flush, illegal and async reset.
module tb_risc_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] ir;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        stall;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [2:0]  ex_rd;
  logic [7:0]  ex_a;
  logic [7:0]  ex_b;
  logic [7:0]  ex_imm;
  logic        ex_we;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        ex_branch;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  risc_decode #(.DW(8), .NREG(8)) dut (
    .clk(clk), .rst(rst), .ir(ir), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_we(ex_we), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_branch(ex_branch),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ir = 13'h0000; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 3'd0; wb_data = 8'h00;
    #12;
    chk("rst_valid", ex_valid, 0);
    rst = 1'b0;
    step();
    chk("nop_valid", ex_valid, 0);
    chk("nop_op", ex_op, 0);
    chk("nop_a", ex_a, 0);
    chk("nop_stall", stall, 0);
    chk("nop_ill", illegal, 0);

    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h05;
    step();
    wb_addr = 3'd1; wb_data = 8'h20;
    step();
    wb_en = 1'b0;
    ir = 13'h0252;
    step();
    chk("add_a", ex_a, 8'h05);
    chk("add_b", ex_b, 8'h05);
    chk("add_rd", ex_rd, 1);
    chk("add_we", ex_we, 1);
    chk("add_valid", ex_valid, 1);
    chk("add_op", ex_op, 1);

    ir = 13'h0CE7;
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h10;
    step();
    wb_en = 1'b0;
    chk("addi_a", ex_a, 8'h10);
    chk("addi_imm", ex_imm, 8'hFF);
    chk("addi_b", ex_b, 8'h00);
    chk("addi_rd", ex_rd, 3);

    ir = 13'h0F48;
    step();
    chk("ld_mem_rd", ex_mem_rd, 1);
    chk("ld_rd", ex_rd, 5);
    chk("ld_a", ex_a, 8'h20);
    ir = 13'h03A8;
    #1;
    chk("lu_stall", stall, 1);
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 8'h33;
    step();
    wb_en = 1'b0;
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_bub_op", ex_op, 0);
    chk("lu_bub_we", ex_we, 0);
    chk("lu_stall_end", stall, 0);
    step();
    chk("lu_add_op", ex_op, 1);
    chk("lu_add_rd", ex_rd, 6);
    chk("lu_add_a", ex_a, 8'h33);
    chk("lu_add_valid", ex_valid, 1);

    ir = 13'h0F48;
    step();
    ir = 13'h1148;
    #1;
    chk("st_stall", stall, 1);
    flush = 1'b1;
    #1;
    chk("fl_stall", stall, 0);
    step();
    flush = 1'b0;
    chk("fl_valid", ex_valid, 0);
    chk("fl_mem_wr", ex_mem_wr, 0);
    step();
    chk("st_mem_wr", ex_mem_wr, 1);
    chk("st_a", ex_a, 8'h20);
    chk("st_b", ex_b, 8'h33);
    chk("st_rd", ex_rd, 0);
    chk("st_we", ex_we, 0);

    ir = 13'h0E08;
    step();
    ir = 13'h0380;
    #1;
    chk("ld_r0_stall", stall, 0);

    ir = 13'h1E00;
    step();
    chk("ill_pulse", illegal, 1);
    chk("ill_valid", ex_valid, 0);
    chk("ill_op", ex_op, 0);
    ir = 13'h0000;
    step();
    chk("ill_drop", illegal, 0);

    ir = 13'h0240;
    wb_en = 1'b1; wb_addr = 3'd0; wb_data = 8'hFF;
    step();
    wb_en = 1'b0;
    chk("r0_bypass", ex_a, 8'h00);
    step();
    chk("r0_read", ex_a, 8'h00);

    ir = 13'h1415;
    step();
    chk("jmp_imm", ex_imm, 8'h15);
    chk("jmp_br", ex_branch, 1);
    chk("jmp_a", ex_a, 8'h00);
    chk("jmp_op", ex_op, 4'hA);

    ir = 13'h126E;
    step();
    chk("beq_a", ex_a, 8'h20);
    chk("beq_b", ex_b, 8'h33);
    chk("beq_imm", ex_imm, 8'hFE);
    chk("beq_br", ex_branch, 1);

    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_op", ex_op, 0);
    chk("arst_br", ex_branch, 0);
    #1;
    rst = 1'b0;
    ir = 13'h0252;
    step();
    chk("post_rst_a", ex_a, 8'h00);
    chk("post_rst_valid", ex_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
